// File: rtl/sd_card_cmd_responder.sv
// rtl/sd_card_cmd_responder.sv - card-side SD CMD line: frame receive/check and short response transmit
//
// Receives 48-bit host command frames on sd_cmd_i (sampled on sd_clk_en_p_i),
// validates CRC7 and end bit, presents index/argument to card logic, then
// serialises the card's 48-bit short response on sd_cmd_o (driven on
// sd_clk_en_n_i) after NcrCycles SD clocks.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   sd_clk_en_p_i / sd_clk_en_n_i  SD clock rising / falling edge enables
//   sd_cmd_i, sd_cmd_o, sd_cmd_en_o CMD line input, output value, output enable
//   cmd_valid_o, cmd_index_o, cmd_arg_o   good command pulse and held fields
//   cmd_crc_err_o                  bad CRC7 / end bit pulse
//   rsp_valid_i, rsp_ready_o, rsp_skip_i, rsp_no_crc_i, rsp_index_i, rsp_arg_i
//                                  response handshake from card logic
//   rsp_timeout_o                  no response offered in time
//   busy_o                         FSM not idle
module sd_card_cmd_responder #(
    parameter int NcrCycles  = 2,
    parameter int RspTimeout = 48
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sd_clk_en_p_i,
    input  logic        sd_clk_en_n_i,
    input  logic        sd_cmd_i,
    output logic        sd_cmd_o,
    output logic        sd_cmd_en_o,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic        cmd_crc_err_o,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    input  logic        rsp_skip_i,
    input  logic        rsp_no_crc_i,
    input  logic [5:0]  rsp_index_i,
    input  logic [31:0] rsp_arg_i,
    output logic        rsp_timeout_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_CHECK,
        S_WAIT_RSP,
        S_NCR,
        S_TX
    } state_t;

    localparam logic [15:0] NCR_LAST = 16'(NcrCycles - 1);
    localparam logic [15:0] RSP_LAST = 16'(RspTimeout - 1);

    state_t      r_state;
    state_t      w_next;
    logic [47:0] r_shift;
    logic [15:0] r_cnt;
    logic        r_cmd_out;
    logic        r_cmd_en;
    logic        r_cmd_valid;
    logic        r_crc_err;
    logic [5:0]  r_cmd_index;
    logic [31:0] r_cmd_arg;

    logic        w_rx_ok;
    logic        w_hs;
    logic [6:0]  w_rsp_crc;

    // CRC7, x^7 + x^3 + 1, zero seed, over the 40 bits preceding the CRC field
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    assign w_rx_ok   = (crc7(r_shift[47:8]) == r_shift[7:1]) && r_shift[0];
    assign w_hs      = rsp_valid_i && (r_state == S_WAIT_RSP);
    assign w_rsp_crc = rsp_no_crc_i ? 7'h7F : crc7({2'b00, rsp_index_i, rsp_arg_i});

    assign sd_cmd_o      = r_cmd_out;
    assign sd_cmd_en_o   = r_cmd_en;
    assign cmd_valid_o   = r_cmd_valid;
    assign cmd_crc_err_o = r_crc_err;
    assign cmd_index_o   = r_cmd_index;
    assign cmd_arg_o     = r_cmd_arg;
    assign busy_o        = (r_state != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        rsp_ready_o   = 1'b0;
        rsp_timeout_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sd_clk_en_p_i && !sd_cmd_i) begin
                    w_next = S_RX;
                end
            end
            S_RX: begin
                if (sd_clk_en_p_i) begin
                    // transmission bit must be 1 for a host-issued frame
                    if (r_cnt == 16'd1 && !sd_cmd_i) begin
                        w_next = S_IDLE;
                    end else if (r_cnt == 16'd47) begin
                        w_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                w_next = w_rx_ok ? S_WAIT_RSP : S_IDLE;
            end
            S_WAIT_RSP: begin
                rsp_ready_o = 1'b1;
                // handshake takes priority over a coincident timeout
                if (w_hs) begin
                    w_next = rsp_skip_i ? S_IDLE : S_NCR;
                end else if (sd_clk_en_p_i && r_cnt == RSP_LAST) begin
                    rsp_timeout_o = 1'b1;
                    w_next        = S_IDLE;
                end
            end
            S_NCR: begin
                if (sd_clk_en_p_i && r_cnt == NCR_LAST) begin
                    w_next = S_TX;
                end
            end
            S_TX: begin
                if (sd_clk_en_n_i && r_cnt == 16'd48) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_cmd_out   <= 1'b1;
            r_cmd_en    <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_crc_err   <= 1'b0;
            r_cmd_index <= '0;
            r_cmd_arg   <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_crc_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_out <= 1'b1;
                    r_cmd_en  <= 1'b0;
                    if (sd_clk_en_p_i && !sd_cmd_i) begin
                        r_shift <= '0;
                        r_cnt   <= 16'd1;
                    end
                end
                S_RX: begin
                    if (sd_clk_en_p_i) begin
                        r_shift <= {r_shift[46:0], sd_cmd_i};
                        r_cnt   <= r_cnt + 16'd1;
                    end
                end
                S_CHECK: begin
                    r_cnt <= '0;
                    if (w_rx_ok) begin
                        r_cmd_index <= r_shift[45:40];
                        r_cmd_arg   <= r_shift[39:8];
                        r_cmd_valid <= 1'b1;
                    end else begin
                        r_crc_err <= 1'b1;
                    end
                end
                S_WAIT_RSP: begin
                    if (w_hs) begin
                        r_cnt <= '0;
                        if (!rsp_skip_i) begin
                            r_shift <= {2'b00, rsp_index_i, rsp_arg_i, w_rsp_crc, 1'b1};
                        end
                    end else if (sd_clk_en_p_i) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_NCR: begin
                    if (sd_clk_en_p_i) begin
                        r_cnt <= (r_cnt == NCR_LAST) ? 16'd0 : r_cnt + 16'd1;
                    end
                end
                S_TX: begin
                    if (sd_clk_en_n_i) begin
                        // r_cnt counts bits already driven; 48 means end bit is out
                        if (r_cnt == 16'd48) begin
                            r_cmd_en  <= 1'b0;
                            r_cmd_out <= 1'b1;
                        end else begin
                            r_cmd_en  <= 1'b1;
                            r_cmd_out <= r_shift[47];
                            r_shift   <= {r_shift[46:0], 1'b0};
                            r_cnt     <= r_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_cmd_out <= 1'b1;
                    r_cmd_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// tb/tb_sd_card_cmd_responder.sv - scoreboard bench for sd_card_cmd_responder
module tb_sd_card_cmd_responder;

    localparam int NCR    = 2;
    localparam int RSP_TO = 48;

    localparam int K_VALID = 0;
    localparam int K_ERR   = 1;
    localparam int K_TO    = 2;

    typedef struct {
        int          kind;
        logic [5:0]  idx;
        logic [31:0] arg;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_p, en_n;
    logic        sd_cmd;
    logic        sd_cmd_o, sd_cmd_en_o;
    logic        cmd_valid_o, cmd_crc_err_o;
    logic [5:0]  cmd_index_o;
    logic [31:0] cmd_arg_o;
    logic        rsp_valid, rsp_skip, rsp_no_crc;
    logic [5:0]  rsp_index;
    logic [31:0] rsp_arg;
    logic        rsp_ready_o, rsp_timeout_o, busy_o;

    int checks = 0;
    int errors = 0;
    int div1   = 0;
    int phase  = 0;

    evt_t        exp_evt[$];
    logic [47:0] exp_frame[$];

    // monitor state
    logic [47:0] frame;
    int          nbits    = 0;
    int          in_frame = 0;
    int          hs_seen  = 0;
    int          hs_cnt   = 0;
    int          wp_cnt   = 0;

    sd_card_cmd_responder #(.NcrCycles(NCR), .RspTimeout(RSP_TO)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .sd_clk_en_p_i(en_p),
        .sd_clk_en_n_i(en_n),
        .sd_cmd_i(sd_cmd),
        .sd_cmd_o(sd_cmd_o),
        .sd_cmd_en_o(sd_cmd_en_o),
        .cmd_valid_o(cmd_valid_o),
        .cmd_index_o(cmd_index_o),
        .cmd_arg_o(cmd_arg_o),
        .cmd_crc_err_o(cmd_crc_err_o),
        .rsp_valid_i(rsp_valid),
        .rsp_ready_o(rsp_ready_o),
        .rsp_skip_i(rsp_skip),
        .rsp_no_crc_i(rsp_no_crc),
        .rsp_index_i(rsp_index),
        .rsp_arg_i(rsp_arg),
        .rsp_timeout_o(rsp_timeout_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // SD clock enables: divide-by-4 (en_p phase 0, en_n phase 2) or divide-by-1
    initial begin
        en_p = 1'b0;
        en_n = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (div1 != 0) begin
                en_p = 1'b1;
                en_n = 1'b1;
            end else begin
                en_p  = (phase == 0);
                en_n  = (phase == 2);
                phase = (phase + 1) % 4;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_evt(input int kind, input logic [5:0] idx, input logic [31:0] arg);
        evt_t e;
        checks++;
        if (exp_evt.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual kind=%0d idx=%0h arg=%0h required none", kind, idx, arg);
        end else begin
            e = exp_evt.pop_front();
            if (e.kind != kind || (kind == K_VALID && (e.idx !== idx || e.arg !== arg))) begin
                errors++;
                $display("FAIL event actual kind=%0d idx=%0h arg=%0h required kind=%0d idx=%0h arg=%0h",
                         kind, idx, arg, e.kind, e.idx, e.arg);
            end
        end
    endtask

    task automatic push_evt(input int kind, input logic [5:0] idx, input logic [31:0] arg);
        evt_t e;
        e.kind = kind;
        e.idx  = idx;
        e.arg  = arg;
        exp_evt.push_back(e);
    endtask

    // monitor: pulses, handshake-to-start spacing, and CMD line frames
    always @(negedge clk) begin
        if (!rst_n) begin
            if (in_frame != 0 && exp_frame.size() > 0) begin
                void'(exp_frame.pop_front());
            end
            in_frame = 0;
            nbits    = 0;
            hs_seen  = 0;
        end else begin
            if (cmd_valid_o) begin
                wp_cnt = en_p ? 1 : 0;
                check_evt(K_VALID, cmd_index_o, cmd_arg_o);
            end else if (en_p) begin
                wp_cnt++;
            end
            if (cmd_crc_err_o) check_evt(K_ERR, 6'd0, 32'd0);
            if (rsp_timeout_o) begin
                check_evt(K_TO, 6'd0, 32'd0);
                chk("timeout_en_p_count", 64'(wp_cnt), 64'(RSP_TO));
            end
            if (rsp_valid && rsp_ready_o) begin
                hs_seen = 1;
                hs_cnt  = 0;
            end else if (hs_seen != 0 && en_p) begin
                hs_cnt++;
            end
            if (sd_cmd_en_o && en_p) begin
                if (in_frame == 0) begin
                    in_frame = 1;
                    nbits    = 0;
                    checks++;
                    if (hs_seen == 0 || hs_cnt < NCR + 1 || hs_cnt > NCR + 2) begin
                        errors++;
                        $display("FAIL ncr_spacing actual=%0d required=%0d..%0d", hs_cnt, NCR + 1, NCR + 2);
                    end
                    hs_seen = 0;
                end
                frame = {frame[46:0], sd_cmd_o};
                nbits++;
            end else if (!sd_cmd_en_o && in_frame != 0) begin
                in_frame = 0;
                if (exp_frame.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=%012h required none", frame);
                end else begin
                    chk("rsp_frame", 64'(frame), 64'(exp_frame.pop_front()));
                    chk("rsp_bits", 64'(nbits), 64'd48);
                end
            end
        end
    end

    task automatic wait_en_p();
        do begin
            @(posedge clk);
        end while (!en_p);
        #1;
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            sd_cmd = f[i];
            wait_en_p();
        end
        sd_cmd = 1'b1;
    endtask

    task automatic respond(input logic skip, input logic no_crc, input logic [5:0] idx, input logic [31:0] arg);
        int ok;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (rsp_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_ready_wait actual=0 required=1");
        end else begin
            rsp_skip   = skip;
            rsp_no_crc = no_crc;
            rsp_index  = idx;
            rsp_arg    = arg;
            rsp_valid  = 1'b1;
            @(posedge clk);
            #1;
            rsp_valid  = 1'b0;
            rsp_skip   = 1'b0;
            rsp_no_crc = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (!busy_o) break;
        end
        chk(name, 64'(busy_o), 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        sd_cmd     = 1'b1;
        rsp_valid  = 1'b0;
        rsp_skip   = 1'b0;
        rsp_no_crc = 1'b0;
        rsp_index  = '0;
        rsp_arg    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sd_cmd_o", 64'(sd_cmd_o), 64'd1);
        chk("rst_sd_cmd_en_o", 64'(sd_cmd_en_o), 64'd0);
        chk("rst_cmd_valid_o", 64'(cmd_valid_o), 64'd0);
        chk("rst_cmd_crc_err_o", 64'(cmd_crc_err_o), 64'd0);
        chk("rst_rsp_ready_o", 64'(rsp_ready_o), 64'd0);
        chk("rst_rsp_timeout_o", 64'(rsp_timeout_o), 64'd0);
        chk("rst_busy_o", 64'(busy_o), 64'd0);
        chk("rst_cmd_index_o", 64'(cmd_index_o), 64'd0);
        chk("rst_cmd_arg_o", 64'(cmd_arg_o), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // CMD0, skipped response
        push_evt(K_VALID, 6'd0, 32'd0);
        send_frame(48'h40_0000_0000_95);
        respond(1'b1, 1'b0, 6'd0, 32'd0);
        wait_idle("cmd0_idle");

        // CMD8 with corrupted CRC byte
        push_evt(K_ERR, 6'd0, 32'd0);
        send_frame(48'h48_0000_01AA_85);
        wait_idle("crcerr_idle");
        chk("crcerr_index_held", 64'(cmd_index_o), 64'd0);
        chk("crcerr_arg_held", 64'(cmd_arg_o), 64'd0);
        chk("crcerr_cmd_released", 64'(sd_cmd_en_o), 64'd0);

        // CMD8 with R7 response
        push_evt(K_VALID, 6'd8, 32'h0000_01AA);
        exp_frame.push_back(48'h08_0000_01AA_13);
        send_frame(48'h48_0000_01AA_87);
        respond(1'b0, 1'b0, 6'd8, 32'h0000_01AA);
        wait_idle("cmd8_idle");

        // R3-style response with forced CRC field
        push_evt(K_VALID, 6'd8, 32'h0000_01AA);
        exp_frame.push_back(48'h3F_80FF_8000_FF);
        send_frame(48'h48_0000_01AA_87);
        respond(1'b0, 1'b1, 6'h3F, 32'h80FF_8000);
        wait_idle("r3_idle");

        // no response offered: timeout, then a normal command
        push_evt(K_VALID, 6'd8, 32'h0000_01AA);
        push_evt(K_TO, 6'd0, 32'd0);
        send_frame(48'h48_0000_01AA_87);
        wait_idle("timeout_idle");
        push_evt(K_VALID, 6'd0, 32'd0);
        send_frame(48'h40_0000_0000_95);
        respond(1'b1, 1'b0, 6'd0, 32'd0);
        wait_idle("post_timeout_idle");

        // reset in the middle of a response
        push_evt(K_VALID, 6'd8, 32'h0000_01AA);
        exp_frame.push_back(48'h08_0000_01AA_13);
        send_frame(48'h48_0000_01AA_87);
        respond(1'b0, 1'b0, 6'd8, 32'h0000_01AA);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (sd_cmd_en_o) break;
        end
        chk("tx_started", 64'(sd_cmd_en_o), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midtx_rst_cmd_en", 64'(sd_cmd_en_o), 64'd0);
        chk("midtx_rst_cmd_o", 64'(sd_cmd_o), 64'd1);
        chk("midtx_rst_busy", 64'(busy_o), 64'd0);
        chk("midtx_rst_index", 64'(cmd_index_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push_evt(K_VALID, 6'd0, 32'd0);
        send_frame(48'h40_0000_0000_95);
        respond(1'b1, 1'b0, 6'd0, 32'd0);
        wait_idle("post_reset_idle");

        // divide-by-1 clocking, CMD8 again
        div1 = 1;
        repeat (3) @(posedge clk);
        #1;
        push_evt(K_VALID, 6'd8, 32'h0000_01AA);
        exp_frame.push_back(48'h08_0000_01AA_13);
        send_frame(48'h48_0000_01AA_87);
        respond(1'b0, 1'b0, 6'd8, 32'h0000_01AA);
        wait_idle("div1_idle");

        repeat (10) @(posedge clk);
        #1;
        chk("events_left", 64'(exp_evt.size()), 64'd0);
        chk("frames_left", 64'(exp_frame.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
